seq_cla_adder: RTL and testbench
================================

# seq_cla_adder

Multi-cycle N-bit adder built from a single 4-bit carry-lookahead slice, reused once per cycle, LSB nibble first. It is the addition counterpart of the 4-bit borrow-lookahead subtractor: same generate/propagate lookahead structure, with carry replacing borrow. It sits behind a valid/ready operand interface and presents a held, valid/ready-qualified sum, so wide additions are serviced with one slice of logic.

## Interface
- WIDTH, 16, operand/sum width in bits. Must be a multiple of 4 and at least 4. NSLICE = WIDTH/4.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set A/B/cin is valid.
- in_ready  output  1  block can accept operands. Equals 1 exactly in state IDLE.
- A  input  WIDTH  augend; sampled at the accept edge.
- B  input  WIDTH  addend; sampled at the accept edge.
- cin  input  1  carry-in to bit 0; sampled at the accept edge.
- out_valid  output  1  S/cout/ovf hold a completed result.
- out_ready  input  1  consumer takes the result.
- S  output  WIDTH  sum, (A + B + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
- Slice logic is combinational:
  - g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
  - c1..c4 are flattened lookahead terms of g, p and c0. No ripple inside the slice.
  - s[i] = p[i] ^ c[i].
- State machine with states IDLE, RUN and DONE; all transitions on the clk rising edge.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1, register A, B and cin into the operand shift registers and the carry register.
  - Clear the slice counter k to 0 and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, feed the low nibbles of the A/B shift registers and the carry register into the slice.
  - Write the 4 sum bits into S bit positions [4k+3:4k].
  - Update the carry register with c4, shift the operands right by 4, and increment k.
  - On the cycle where k = NSLICE-1:
    - Latch cout = c4.
    - Latch ovf = c3 ^ c4 of that slice.
    - Go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - S, cout and ovf are held stable.
  - On out_ready=1, go to IDLE. out_valid drops next cycle.
  - in_valid is ignored in RUN and DONE. Operands presented then are neither captured nor queued.
- S bits not yet written in RUN are don't-care. S, cout and ovf are only meaningful while out_valid=1.
- Reset (any state, including mid-RUN or DONE):
  - Next state IDLE.
  - S=0, cout=0, ovf=0, out_valid=0, k=0, carry register=0.
  - in_ready=1 from the first cycle after the reset edge.
  - An in-flight operation is discarded and never produces out_valid.
- No arithmetic width growth. The carry out of bit WIDTH-1 goes only to cout.

## Timing
- Accept edge T0: first edge with state=IDLE, in_valid=1, rst=0.
- The RUN cycles fall between edges T0 and T0+NSLICE.
- out_valid=1 from edge T0+NSLICE. Latency is NSLICE cycles (4 for WIDTH=16).
- If out_ready=1 already at the first DONE cycle, the handshake completes at edge T0+NSLICE+1.
  - in_ready=1 in that following cycle.
  - Minimum initiation interval is NSLICE+2 cycles.
- Result fields must not change while out_valid=1 and out_ready=0.
- rst has priority over every handshake event on the same edge.

## Test plan
- WIDTH=16: accept A=0x00FF, B=0x0001, cin=0.
  - out_valid rises exactly 4 cycles after the accept edge.
  - S=0x0100, cout=0, ovf=0.
- A=0xFFFF, B=0x0001, cin=0 -> S=0x0000, cout=1, ovf=0. This checks the carry chaining across all 4 slices.
- A=0x7FFF, B=0x0001 -> S=0x8000, cout=0, ovf=1.
- A=0x8000, B=0x8000 -> S=0x0000, cout=1, ovf=1.
- A=0x1234, B=0x4321, cin=1 -> S=0x5556, cout=0, ovf=0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - S/cout/ovf must stay stable and in_ready must stay 0.
  - After out_ready=1: IDLE, then the new operands are accepted.
  - Assert rst during the second RUN cycle: out_valid stays 0, in_ready=1 on the next cycle, and the outputs are all zero.

Source files
------------

// File: rtl/seq_cla_adder_if.sv
// Operand/result handshake bundle for the sequential carry-lookahead adder.
// The master side presents operands and consumes sums; the slave side is the adder.
interface seq_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, cout, ovf
    );

    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, cout, ovf
    );
endinterface

// File: rtl/seq_cla_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-lookahead slice per cycle,
// LSB nibble first, behind a valid/ready operand port and a held valid/ready result.
module seq_cla_adder #(
    parameter int WIDTH = 16
) (
    input logic           clk,
    input logic           rst,
    seq_cla_adder_if.slave bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             last_slice;

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] s_slice;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;

    // One 4-bit lookahead slice; every carry is a flat sum of products, no ripple.
    assign g  = a_sh[3:0] & b_sh[3:0];
    assign p  = a_sh[3:0] ^ b_sh[3:0];
    assign c1 = g[0] | (p[0] & carry);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & carry);
    assign c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry);
    assign s_slice = p ^ {c3, c2, c1, carry};

    assign last_slice = (k == K_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.in_valid)  next_state = RUN;
            RUN:     if (last_slice)    next_state = DONE;
            DONE:    if (bus.out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands shift right one nibble per RUN cycle so the slice always sees bits [3:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            k      <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.cin;
                        k     <= '0;
                    end
                end
                RUN: begin
                    sum_r[{k, 2'b00} +: 4] <= s_slice;
                    carry <= c4;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    k     <= k + 1'b1;
                    if (last_slice) begin
                        cout_r <= c4;
                        ovf_r  <= c3 ^ c4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.S         = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_seq_cla_adder.sv
// Scoreboard bench for seq_cla_adder: expected sums come from a plain integer-add
// model, are queued when operands are driven and popped when out_valid appears.
module tb_seq_cla_adder;
    localparam int WIDTH    = 16;
    localparam int NSLICE   = WIDTH / 4;
    localparam int MAX_WAIT = 40;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             cout;
        logic             ovf;
    } result_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             c;
    } vector_t;

    logic    clk = 1'b0;
    logic    rst;
    result_t sb[$];
    int      checks = 0;
    int      errors = 0;

    seq_cla_adder_if #(.WIDTH(WIDTH)) bus ();

    seq_cla_adder #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference result straight from wide integer addition and operand signs.
    function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic c);
        logic [WIDTH:0] full;
        result_t        r;
        full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
        r.s    = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; holds in_valid for exactly one rising edge.
    task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.cin      = c;
        sb.push_back(model(a, b, c));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out_valid(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < MAX_WAIT) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.cin       = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if ({bus.S, bus.cout, bus.ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got S=%h cout=%b ovf=%b expected all zero",
                     bus.S, bus.cout, bus.ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_latency;
        int      cycles;
        result_t exp;
        apply_stimulus(16'h00FF, 16'h0001, 1'b0);
        wait_out_valid(cycles);
        checks++;
        if (cycles !== NSLICE) begin
            errors++;
            $display("[TB] FAIL latency: got %0d cycles expected %0d", cycles, NSLICE);
        end
        exp = sb.pop_front();
        checks++;
        if ({bus.S, bus.cout, bus.ovf} !== exp) begin
            errors++;
            $display("[TB] FAIL latency_result: got S=%h cout=%b ovf=%b expected S=%h cout=%b ovf=%b",
                     bus.S, bus.cout, bus.ovf, exp.s, exp.cout, exp.ovf);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_handshake: got in_ready=%b out_valid=%b expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_arith;
        vector_t vec[$];
        int      cycles;
        result_t exp;
        vec.push_back({16'hFFFF, 16'h0001, 1'b0});
        vec.push_back({16'h7FFF, 16'h0001, 1'b0});
        vec.push_back({16'h8000, 16'h8000, 1'b0});
        vec.push_back({16'h1234, 16'h4321, 1'b1});
        vec.push_back({16'hFFFF, 16'hFFFF, 1'b1});
        vec.push_back({16'h0000, 16'h0000, 1'b1});
        for (int i = 0; i < 6; i++) begin
            vec.push_back({WIDTH'($urandom), WIDTH'($urandom), 1'($urandom)});
        end
        foreach (vec[i]) begin
            apply_stimulus(vec[i].a, vec[i].b, vec[i].c);
            wait_out_valid(cycles);
            checks++;
            if (cycles >= MAX_WAIT) begin
                errors++;
                $display("[TB] FAIL arith_timeout[%0d]: got no out_valid within %0d cycles", i, MAX_WAIT);
            end
            exp = sb.pop_front();
            checks++;
            if (bus.S !== exp.s) begin
                errors++;
                $display("[TB] FAIL arith_S[%0d] %h+%h+%b: got %h expected %h",
                         i, vec[i].a, vec[i].b, vec[i].c, bus.S, exp.s);
            end
            checks++;
            if (bus.cout !== exp.cout) begin
                errors++;
                $display("[TB] FAIL arith_cout[%0d] %h+%h+%b: got %b expected %b",
                         i, vec[i].a, vec[i].b, vec[i].c, bus.cout, exp.cout);
            end
            checks++;
            if (bus.ovf !== exp.ovf) begin
                errors++;
                $display("[TB] FAIL arith_ovf[%0d] %h+%h+%b: got %b expected %b",
                         i, vec[i].a, vec[i].b, vec[i].c, bus.ovf, exp.ovf);
            end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure;
        int      cycles;
        result_t exp;
        result_t held;
        apply_stimulus(16'hA5C3, 16'h3C5A, 1'b1);
        wait_out_valid(cycles);
        exp = sb.pop_front();
        bus.in_valid = 1'b1;
        bus.A        = 16'h7FFF;
        bus.B        = 16'h0001;
        bus.cin      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            held = {bus.S, bus.cout, bus.ovf};
            checks++;
            if (held !== exp || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL hold[%0d]: got S=%h cout=%b ovf=%b valid=%b ready=%b expected S=%h cout=%b ovf=%b valid=1 ready=0",
                         i, bus.S, bus.cout, bus.ovf, bus.out_valid, bus.in_ready,
                         exp.s, exp.cout, exp.ovf);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
        sb.push_back(model(bus.A, bus.B, bus.cin));
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_out_valid(cycles);
        checks++;
        if (cycles !== NSLICE) begin
            errors++;
            $display("[TB] FAIL bp_new_latency: got %0d cycles expected %0d", cycles, NSLICE);
        end
        exp = sb.pop_front();
        checks++;
        if ({bus.S, bus.cout, bus.ovf} !== exp) begin
            errors++;
            $display("[TB] FAIL bp_new_result: got S=%h cout=%b ovf=%b expected S=%h cout=%b ovf=%b",
                     bus.S, bus.cout, bus.ovf, exp.s, exp.cout, exp.ovf);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int      cycles;
        result_t exp;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            apply_stimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_out_valid(cycles);
            exp = sb.pop_front();
            checks++;
            if (cycles !== NSLICE || {bus.S, bus.cout, bus.ovf} !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_result[%0d]: got %0d cycles S=%h cout=%b ovf=%b expected %0d cycles S=%h cout=%b ovf=%b",
                         i, cycles, bus.S, bus.cout, bus.ovf, NSLICE, exp.s, exp.cout, exp.ovf);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int      cycles;
        int      seen_valid;
        result_t exp;
        apply_stimulus(16'h1111, 16'h2222, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_handshake: got in_ready=%b out_valid=%b expected 1/0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if ({bus.S, bus.cout, bus.ovf} !== '0) begin
            errors++;
            $display("[TB] FAIL midrun_outputs: got S=%h cout=%b ovf=%b expected all zero",
                     bus.S, bus.cout, bus.ovf);
        end
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.out_valid === 1'b1) seen_valid++;
            @(negedge clk);
        end
        checks++;
        if (seen_valid !== 0) begin
            errors++;
            $display("[TB] FAIL midrun_discard: got out_valid in %0d cycles expected 0", seen_valid);
        end
        apply_stimulus(16'h8001, 16'h7FFF, 1'b0);
        wait_out_valid(cycles);
        exp = sb.pop_front();
        checks++;
        if (cycles !== NSLICE || {bus.S, bus.cout, bus.ovf} !== exp) begin
            errors++;
            $display("[TB] FAIL post_reset_result: got %0d cycles S=%h cout=%b ovf=%b expected %0d cycles S=%h cout=%b ovf=%b",
                     cycles, bus.S, bus.cout, bus.ovf, NSLICE, exp.s, exp.cout, exp.ovf);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
